pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central controller for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It sequences execution in continuous or single-step mode under debug-unit command, inserts load-use bubbles, flushes wrong-path fetches on taken branches, and drains the pipe after a HALT. It sits beside the datapath and drives every latch `i_enable` plus the synchronous flush inputs of IF/ID and ID/EX.

## Interface
- `SIZE_REG_ADDR`, 5, register-address width.
- `DRAIN_CYCLES`, 4, advance cycles after HALT detection before DONE.
- `CNT_W`, 32, cycle-counter width.

- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  synchronous, active-high.
- `i_start`  in  1  start pulse from the debug unit.
- `i_mode_step`  in  1  sampled with `i_start`: 1 = step mode, 0 = run mode.
- `i_step`  in  1  single-step pulse.
- `i_halt_id`  in  1  HALT opcode decoded in ID.
- `i_branch_taken`  in  1  branch/jump resolved taken in ID.
- `i_id_ex_mem_read`  in  1  instruction in ID/EX is a load.
- `i_id_ex_rt`  in  SIZE_REG_ADDR  load destination held in ID/EX.
- `i_if_id_rs`, `i_if_id_rt`  in  SIZE_REG_ADDR  source registers of the instruction in ID.
- `o_pc_en`, `o_if_id_en`, `o_id_ex_en`, `o_ex_mem_en`, `o_mem_wb_en`  out  1  latch enables.
- `o_if_id_flush`, `o_id_ex_flush`  out  1  synchronous clear at next edge.
- `o_state`  out  3  current state.
- `o_done`  out  1  program finished.
- `o_cycle_count`  out  CNT_W  advance cycles since start.

## Operation
- States: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.
- IDLE: `i_start` with `i_mode_step`=0 goes to RUN; with 1 goes to STEP_WAIT. The counter clears on that start.
- RUN: advances every cycle. `i_halt_id` goes to DRAIN.
- STEP_WAIT: `i_step` goes to STEP_EXEC.
- STEP_EXEC: exactly one advance cycle. Goes to DRAIN if `i_halt_id`, else back to STEP_WAIT.
- DRAIN: free-running in both modes. A drain counter loads DRAIN_CYCLES on entry and decrements every cycle. At 1 it goes to DONE.
- DONE: all enables 0, `o_done`=1. Held until `i_reset`.
- Advance cycle = state RUN or STEP_EXEC or DRAIN. In every other state all enables and flushes are 0.
- In an advance cycle, the default is all five enables = 1 and both flushes = 0.
- Load-use hazard (lu): `i_id_ex_mem_read` && `i_id_ex_rt`≠0 && (`i_id_ex_rt`==`i_if_id_rs` || `i_id_ex_rt`==`i_if_id_rt`).
  - Response: `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1.
  - EX/MEM and MEM/WB still advance.
- Taken branch: `o_if_id_flush`=1, PC enabled.
- HALT in ID (RUN/STEP_EXEC) and every DRAIN cycle: `o_pc_en`=0, `o_if_id_flush`=1. Downstream latches stay enabled.
- Priority: halt/DRAIN > lu > branch. A masked branch is re-evaluated when the stall releases.
- `o_cycle_count` increments on every advance cycle, including stall cycles, and saturates at all-ones.
- Ignored inputs:
  - `i_start` outside IDLE.
  - `i_step` outside STEP_WAIT.
  - `i_mode_step` except with `i_start`.

## Timing
- Enables and flushes are combinational from the registered state and the current-cycle hazard inputs: zero-cycle stall response.
- `o_state`, `o_done`, `o_cycle_count` and the drain counter are registered.
- On the edge after reset: state=IDLE, all enables/flushes=0, `o_done`=0, `o_cycle_count`=0, drain counter=0.
- Reset mid-operation (any state) returns to IDLE on the next edge. Latch contents are the datapath's concern.
- Start latency: `i_start` at edge N puts the state in RUN/STEP_WAIT after N. The first advance is the cycle after N.
- Step: one `i_step` yields exactly one advance cycle (STEP_EXEC) on the following cycle. `i_step` held high yields one advance every 2 cycles.
- HALT seen at cycle H, then DRAIN for DRAIN_CYCLES cycles, then DONE.

## Structure
- Shared package `pipeline_pkg`:
  - state encodings and `STATE_W`=3;
  - default DRAIN_CYCLES;
  - register-zero constant.
- One combinational sub-module `hazard_detect` computes lu. It is reusable by a later forwarding unit.
- The FSM, drain counter, cycle counter and enable/flush muxing live in `pipeline_sequencer`.

## Test plan
- Reset, then `i_start`=1, `i_mode_step`=0: state 0→1, all enables 1. After 10 cycles with no hazards, `o_cycle_count`=10.
- RUN, `i_id_ex_mem_read`=1, `i_id_ex_rt`=5, `i_if_id_rs`=5 for one cycle: `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1, `o_ex_mem_en`=1. Same case with `i_id_ex_rt`=0: no stall.
- RUN, `i_branch_taken`=1 together with a load-use: no IF/ID flush that cycle. Next cycle, branch only: `o_if_id_flush`=1, `o_pc_en`=1.
- Step mode, three `i_step` pulses 5 cycles apart: exactly 3 advance cycles, `o_cycle_count`=3. `i_step` during STEP_EXEC is ignored.
- `i_halt_id` at cycle H in RUN: DRAIN for 4 cycles with `o_pc_en`=0 and `o_if_id_flush`=1, then `o_done`=1 and all enables 0. A later `i_start` is ignored.
- `i_reset` mid-DRAIN: next state IDLE, `o_cycle_count`=0, `o_done`=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline control slice: sequencer state
// encodings, the default drain length after HALT and the register-zero
// address used by hazard logic.
package pipeline_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_STEP_WAIT = 3'd2,
      ST_STEP_EXEC = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   // Advance cycles spent emptying the pipe once HALT has been decoded.
   localparam int DEFAULT_DRAIN_CYCLES = 4;

   // Register $zero is hard-wired, so a load targeting it never creates a hazard.
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Purely combinational load-use detector. Flags the case where the load
// sitting in ID/EX writes a register that the instruction in ID reads.
// Kept separate so a later forwarding unit can reuse it.
//
// Ports:
//   mem_read  in   instruction in ID/EX is a load
//   load_rt   in   destination register of that load
//   src_rs    in   first source register of the instruction in ID
//   src_rt    in   second source register of the instruction in ID
//   load_use  out  1 when ID must wait one cycle for the load data
module hazard_detect
   import pipeline_pkg::*;
#(
   parameter int SIZE_REG_ADDR = 5
) (
   input  logic                     mem_read,
   input  logic [SIZE_REG_ADDR-1:0] load_rt,
   input  logic [SIZE_REG_ADDR-1:0] src_rs,
   input  logic [SIZE_REG_ADDR-1:0] src_rt,
   output logic                     load_use
);

   localparam logic [SIZE_REG_ADDR-1:0] ZERO_ADDR = SIZE_REG_ADDR'(REG_ZERO);

   // A load into $zero writes nothing, so it can never stall a consumer.
   assign load_use = mem_read && (load_rt != ZERO_ADDR) &&
                     ((load_rt == src_rs) || (load_rt == src_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central controller for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB latches.
// Runs the pipe continuously or one instruction per step pulse, inserts
// load-use bubbles, flushes wrong-path fetches on taken branches and drains
// the pipe after HALT before reporting done.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_start, i_mode_step     start pulse and mode (1 = step) sampled with it
//   i_step                   single-step pulse
//   i_halt_id                HALT decoded in ID
//   i_branch_taken           branch/jump resolved taken in ID
//   i_id_ex_mem_read/_rt     load info held in ID/EX
//   i_if_id_rs/_rt           source registers of the instruction in ID
//   o_*_en                   latch enables (combinational)
//   o_if_id_flush/_id_ex_flush  synchronous clears at the next edge
//   o_state, o_done          current state, program finished
//   o_cycle_count            saturating count of advance cycles since start
module pipeline_sequencer
   import pipeline_pkg::*;
#(
   parameter int SIZE_REG_ADDR = 5,
   parameter int DRAIN_CYCLES  = DEFAULT_DRAIN_CYCLES,
   parameter int CNT_W         = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic                     i_mode_step,
   input  logic                     i_step,
   input  logic                     i_halt_id,
   input  logic                     i_branch_taken,
   input  logic                     i_id_ex_mem_read,
   input  logic [SIZE_REG_ADDR-1:0] i_id_ex_rt,
   input  logic [SIZE_REG_ADDR-1:0] i_if_id_rs,
   input  logic [SIZE_REG_ADDR-1:0] i_if_id_rt,
   output logic                     o_pc_en,
   output logic                     o_if_id_en,
   output logic                     o_id_ex_en,
   output logic                     o_ex_mem_en,
   output logic                     o_mem_wb_en,
   output logic                     o_if_id_flush,
   output logic                     o_id_ex_flush,
   output logic [STATE_W-1:0]       o_state,
   output logic                     o_done,
   output logic [CNT_W-1:0]         o_cycle_count
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   state_t               state;
   state_t               next_state;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic [CNT_W-1:0]     cycle_count;
   logic                 load_use;
   logic                 advance;
   logic                 halt_now;

   hazard_detect #(
      .SIZE_REG_ADDR (SIZE_REG_ADDR)
   ) u_hazard_detect (
      .mem_read (i_id_ex_mem_read),
      .load_rt  (i_id_ex_rt),
      .src_rs   (i_if_id_rs),
      .src_rt   (i_if_id_rt),
      .load_use (load_use)
   );

   // Cycles in which the pipe moves; HALT in ID and every drain cycle stop
   // new fetches while letting older instructions retire.
   assign advance  = (state == ST_RUN) || (state == ST_STEP_EXEC) || (state == ST_DRAIN);
   assign halt_now = (state == ST_DRAIN) ||
                     (((state == ST_RUN) || (state == ST_STEP_EXEC)) && i_halt_id);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state plus latch enables/flushes. Priority is halt/drain, then
   // load-use, then branch; a branch masked by a stall is simply seen again
   // once the stall releases because ID still holds it.
   always_comb begin
      next_state    = state;
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_en    = 1'b0;
      o_ex_mem_en   = 1'b0;
      o_mem_wb_en   = 1'b0;
      o_if_id_flush = 1'b0;
      o_id_ex_flush = 1'b0;

      case (state)
         ST_IDLE:      if (i_start) next_state = i_mode_step ? ST_STEP_WAIT : ST_RUN;
         ST_RUN:       if (i_halt_id) next_state = ST_DRAIN;
         ST_STEP_WAIT: if (i_step) next_state = ST_STEP_EXEC;
         ST_STEP_EXEC: next_state = i_halt_id ? ST_DRAIN : ST_STEP_WAIT;
         ST_DRAIN:     if (drain_cnt == DRAIN_W'(1)) next_state = ST_DONE;
         ST_DONE:      next_state = ST_DONE;
         default:      next_state = ST_IDLE;
      endcase

      if (advance) begin
         o_pc_en     = 1'b1;
         o_if_id_en  = 1'b1;
         o_id_ex_en  = 1'b1;
         o_ex_mem_en = 1'b1;
         o_mem_wb_en = 1'b1;
         if (halt_now) begin
            o_pc_en       = 1'b0;
            o_if_id_flush = 1'b1;
         end else if (load_use) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
         end else if (i_branch_taken) begin
            o_if_id_flush = 1'b1;
         end
      end
   end

   // Drain counter: loaded on the way into DRAIN, counts down each drain
   // cycle; DRAIN exits when it reads 1.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         drain_cnt <= '0;
      end else if ((state != ST_DRAIN) && (next_state == ST_DRAIN)) begin
         drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
         drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
   end

   // Advance-cycle counter, cleared by an accepted start and saturating.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cycle_count <= '0;
      end else if ((state == ST_IDLE) && i_start) begin
         cycle_count <= '0;
      end else if (advance && (cycle_count != '1)) begin
         cycle_count <= cycle_count + CNT_W'(1);
      end
   end

   assign o_state       = state;
   assign o_done        = (state == ST_DONE);
   assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Directed-plus-random bench for pipeline_sequencer. A cycle-level model of
// the sequencing rules predicts state, done, cycle count and every enable and
// flush; all outputs are compared on the falling edge of each cycle.
module tb_pipeline_sequencer;

   localparam int SIZE_REG_ADDR = 5;
   localparam int DRAIN_CYCLES  = 4;
   localparam int CNT_W         = 32;

   // Spec state numbering used by the model.
   localparam int S_IDLE = 0, S_RUN = 1, S_STEP_WAIT = 2, S_STEP_EXEC = 3, S_DRAIN = 4, S_DONE = 5;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     start;
   logic                     mode_step;
   logic                     step;
   logic                     halt_id;
   logic                     branch_taken;
   logic                     mem_read;
   logic [SIZE_REG_ADDR-1:0] ex_rt;
   logic [SIZE_REG_ADDR-1:0] id_rs;
   logic [SIZE_REG_ADDR-1:0] id_rt;
   logic                     pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic                     if_id_flush, id_ex_flush;
   logic [2:0]               state_out;
   logic                     done;
   logic [CNT_W-1:0]         cycle_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit      m_valid = 1'b0;
   int      m_state;
   int      m_drain_done;
   longint  m_count;

   always #5 clk = ~clk;

   pipeline_sequencer #(
      .SIZE_REG_ADDR (SIZE_REG_ADDR),
      .DRAIN_CYCLES  (DRAIN_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_mode_step      (mode_step),
      .i_step           (step),
      .i_halt_id        (halt_id),
      .i_branch_taken   (branch_taken),
      .i_id_ex_mem_read (mem_read),
      .i_id_ex_rt       (ex_rt),
      .i_if_id_rs       (id_rs),
      .i_if_id_rt       (id_rt),
      .o_pc_en          (pc_en),
      .o_if_id_en       (if_id_en),
      .o_id_ex_en       (id_ex_en),
      .o_ex_mem_en      (ex_mem_en),
      .o_mem_wb_en      (mem_wb_en),
      .o_if_id_flush    (if_id_flush),
      .o_id_ex_flush    (id_ex_flush),
      .o_state          (state_out),
      .o_done           (done),
      .o_cycle_count    (cycle_count)
   );

   // One comparison with failure accounting.
   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Predict this cycle's outputs from the model state and current inputs.
   task automatic check_output();
      bit adv, halting, lu;
      if (!m_valid) return;
      adv     = (m_state == S_RUN) || (m_state == S_STEP_EXEC) || (m_state == S_DRAIN);
      halting = (m_state == S_DRAIN) || (((m_state == S_RUN) || (m_state == S_STEP_EXEC)) && halt_id);
      lu      = mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      check_value("state",       32'(state_out),   32'(m_state));
      check_value("done",        32'(done),        32'(m_state == S_DONE));
      check_value("cycle_count", cycle_count,      32'(m_count));
      check_value("pc_en",       32'(pc_en),       32'(adv && !halting && !lu));
      check_value("if_id_en",    32'(if_id_en),    32'(adv && (halting || !lu)));
      check_value("id_ex_en",    32'(id_ex_en),    32'(adv));
      check_value("ex_mem_en",   32'(ex_mem_en),   32'(adv));
      check_value("mem_wb_en",   32'(mem_wb_en),   32'(adv));
      check_value("if_id_flush", 32'(if_id_flush), 32'(adv && (halting || (!lu && branch_taken))));
      check_value("id_ex_flush", 32'(id_ex_flush), 32'(adv && !halting && lu));
   endtask

   // Advance the model across one rising edge.
   task automatic update_model();
      if (reset) begin
         m_valid = 1'b1;
         m_state = S_IDLE;
         m_count = 0;
         m_drain_done = 0;
         return;
      end
      if (!m_valid) return;
      if ((m_state == S_RUN) || (m_state == S_STEP_EXEC) || (m_state == S_DRAIN))
         if (m_count < 64'hFFFF_FFFF) m_count++;
      case (m_state)
         S_IDLE: if (start) begin
            m_state = mode_step ? S_STEP_WAIT : S_RUN;
            m_count = 0;
         end
         S_RUN: if (halt_id) begin
            m_state = S_DRAIN;
            m_drain_done = 0;
         end
         S_STEP_WAIT: if (step) m_state = S_STEP_EXEC;
         S_STEP_EXEC: begin
            m_drain_done = 0;
            m_state = halt_id ? S_DRAIN : S_STEP_WAIT;
         end
         S_DRAIN: begin
            m_drain_done++;
            if (m_drain_done == DRAIN_CYCLES) m_state = S_DONE;
         end
         default: m_state = m_state;
      endcase
   endtask

   // Run one clock cycle with the inputs currently driven.
   task automatic apply_stimulus();
      @(negedge clk);
      check_output();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic random_hazards();
      mem_read     = 1'($urandom_range(0, 1));
      ex_rt        = SIZE_REG_ADDR'($urandom_range(0, 3));
      id_rs        = SIZE_REG_ADDR'($urandom_range(0, 3));
      id_rt        = SIZE_REG_ADDR'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
   endtask

   task automatic quiet_hazards();
      mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; branch_taken = 0;
   endtask

   initial begin
      reset = 1; start = 0; mode_step = 0; step = 0; halt_id = 0;
      quiet_hazards();
      #1;
      apply_stimulus();
      apply_stimulus();
      reset = 0;
      apply_stimulus();

      $display("[TB] run mode start and 10 quiet cycles");
      start = 1; mode_step = 0;
      apply_stimulus();
      start = 0;
      repeat (10) apply_stimulus();
      check_value("count_after_10", cycle_count, 32'd10);

      $display("[TB] load-use stall and register-zero load");
      mem_read = 1; ex_rt = 5; id_rs = 5; id_rt = 7;
      apply_stimulus();
      ex_rt = 0; id_rs = 0; id_rt = 0;
      apply_stimulus();

      $display("[TB] branch masked by stall, then branch alone");
      mem_read = 1; ex_rt = 3; id_rs = 1; id_rt = 3; branch_taken = 1;
      apply_stimulus();
      mem_read = 0;
      apply_stimulus();
      quiet_hazards();

      $display("[TB] random hazards in run mode, start ignored");
      for (int i = 0; i < 30; i++) begin
         random_hazards();
         start = (i == 7);
         mode_step = 1;
         apply_stimulus();
      end
      start = 0; mode_step = 0;

      $display("[TB] halt, drain and done");
      halt_id = 1;
      random_hazards();
      apply_stimulus();
      halt_id = 0;
      for (int i = 0; i < DRAIN_CYCLES; i++) begin
         random_hazards();
         apply_stimulus();
      end
      check_value("done_after_drain", 32'(done), 32'd1);
      start = 1;
      repeat (3) apply_stimulus();
      start = 0;

      $display("[TB] step mode");
      reset = 1;
      apply_stimulus();
      reset = 0;
      start = 1; mode_step = 1;
      apply_stimulus();
      start = 0; mode_step = 0;
      for (int p = 0; p < 3; p++) begin
         random_hazards();
         step = 1;
         apply_stimulus();
         step = 0;
         repeat (4) begin
            random_hazards();
            apply_stimulus();
         end
      end
      check_value("count_after_3_steps", cycle_count, 32'd3);
      step = 1;
      repeat (6) begin
         random_hazards();
         apply_stimulus();
      end
      step = 0;

      $display("[TB] halt ignored in STEP_WAIT, taken in STEP_EXEC, reset mid-drain");
      halt_id = 1;
      apply_stimulus();
      step = 1;
      apply_stimulus();
      step = 0;
      apply_stimulus();
      halt_id = 0;
      repeat (2) apply_stimulus();
      reset = 1;
      apply_stimulus();
      reset = 0;
      apply_stimulus();

      $display("[TB] random everything");
      for (int i = 0; i < 300; i++) begin
         random_hazards();
         reset     = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 3) == 0);
         mode_step = 1'($urandom_range(0, 1));
         step      = 1'($urandom_range(0, 1));
         halt_id   = ($urandom_range(0, 15) == 0);
         apply_stimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
